// File: rtl/stoch_pkg.sv
// Shared types and helpers for the signed stochastic datapath.
// Signed channels carry a value as a (p, m) bit pair per cycle.
package stoch_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_ACCUM,
        DEC_HOLD
    } dec_state_t;

    // +1 for p only, -1 for m only, 0 when the channels cancel.
    function automatic logic signed [1:0] stoch_step(input logic p, input logic m);
        if (p && !m) begin
            return 2'sb01;
        end else if (!p && m) begin
            return 2'sb11;
        end else begin
            return 2'sb00;
        end
    endfunction

endpackage

// File: rtl/stoch_updown_counter.sv
// Signed up/down accumulator: adds a sign-extended 2-bit step when enabled.
// A synchronous clear takes priority over the enable.
module stoch_updown_counter #(
    parameter int WIDTH = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [1:0]       step,
    output logic signed [WIDTH-1:0] count
);

    logic signed [WIDTH-1:0] step_ext;

    assign step_ext = {{(WIDTH-2){step[1]}}, step};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + step_ext;
        end
    end

endmodule

// File: rtl/stoch_signed_decoder.sv
// Integrates (p - m) of a signed stochastic stream over WINDOW cycles and
// presents the signed sum on a valid/ready handshake.
//
// state     | meaning
// DEC_IDLE  | waiting for start; value keeps the last result
// DEC_ACCUM | sampling in_p/in_m, one sample per edge
// DEC_HOLD  | result valid, waiting for out_ready
module stoch_signed_decoder
    import stoch_pkg::*;
#(
    parameter int WINDOW  = 256,
    parameter int COUNT_W = $clog2(WINDOW + 1) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               in_p,
    input  logic               in_m,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] value
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    dec_state_t              state;
    dec_state_t              state_d;
    logic [CNT_W-1:0]        cnt;
    logic                    clr;
    logic                    en;
    logic                    load;
    logic signed [1:0]       step;
    logic signed [COUNT_W-1:0] acc;
    logic signed [COUNT_W-1:0] sum_final;

    assign step      = stoch_step(in_p, in_m);
    // The last sample is folded in combinationally so value loads on the same edge.
    assign sum_final = acc + {{(COUNT_W-2){step[1]}}, step};

    stoch_updown_counter #(
        .WIDTH(COUNT_W)
    ) u_acc (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (clr),
        .en   (en),
        .step (step),
        .count(acc)
    );

    always_comb begin
        state_d = state;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        case (state)
            DEC_IDLE: begin
                if (start) begin
                    state_d = DEC_ACCUM;
                    clr     = 1'b1;
                end
            end
            DEC_ACCUM: begin
                en = 1'b1;
                if (cnt == LAST) begin
                    state_d = DEC_HOLD;
                    load    = 1'b1;
                end
            end
            DEC_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = DEC_ACCUM;
                        clr     = 1'b1;
                    end else begin
                        state_d = DEC_IDLE;
                    end
                end
            end
            default: state_d = DEC_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= DEC_IDLE;
            cnt   <= '0;
            value <= '0;
        end else begin
            state <= state_d;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (load) begin
                value <= sum_final;
            end
        end
    end

    assign busy      = (state == DEC_ACCUM);
    assign out_valid = (state == DEC_HOLD);

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// Bench for stoch_signed_decoder at WINDOW=8: vector table plus hand-written
// sequences for stall, back-to-back, ignored start and mid-window reset.
module tb_stoch_signed_decoder;

    localparam int WINDOW  = 8;
    localparam int COUNT_W = 5;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               start = 1'b0;
    logic               in_p = 1'b0;
    logic               in_m = 1'b0;
    logic               busy;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [COUNT_W-1:0] value;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0] p;
        logic [7:0] m;
        int         expv;
    } vec_t;

    vec_t vecs[8];

    stoch_signed_decoder #(
        .WINDOW(WINDOW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .in_p     (in_p),
        .in_m     (in_m),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .value    (value)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sval(input logic [COUNT_W-1:0] v);
        return int'($signed(v));
    endfunction

    // Drives the 8 samples of a window; start_mask re-pulses start on chosen samples.
    task automatic drive_samples(input logic [7:0] p, input logic [7:0] m,
                                 input logic [7:0] start_mask);
        for (int i = 0; i < WINDOW; i++) begin
            in_p  = p[i];
            in_m  = m[i];
            start = start_mask[i];
            if (i == 0) check("busy_in_accum", int'(busy), 1);
            if (i == WINDOW - 1) check("valid_not_early", int'(out_valid), 0);
            tick();
        end
        start = 1'b0;
        in_p  = 1'b0;
        in_m  = 1'b0;
        check("valid_on_time", int'(out_valid), 1);
        check("busy_after_window", int'(busy), 0);
    endtask

    task automatic convert(input logic [7:0] p, input logic [7:0] m,
                           input logic [7:0] start_mask, input int expv);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(expv);
        drive_samples(p, m, start_mask);
    endtask

    // Compares the held result against the scoreboard; optional back-to-back start.
    task automatic consume(input logic restart, input int next_exp);
        int e;
        if (!out_valid) begin
            check("consume_valid", int'(out_valid), 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            e = 0;
        end else begin
            e = exp_q.pop_front();
        end
        check("value", sval(value), e);
        out_ready = 1'b1;
        start     = restart;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        if (restart) begin
            exp_q.push_back(next_exp);
            check("b2b_busy", int'(busy), 1);
        end else begin
            check("idle_after_accept", int'(busy), 0);
        end
        check("valid_cleared", int'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h00,  8};
        vecs[1] = '{8'h00, 8'hFF, -8};
        vecs[2] = '{8'hDF, 8'hE0,  4};
        vecs[3] = '{8'hFF, 8'hFF,  0};
        vecs[4] = '{8'h01, 8'h00,  1};
        vecs[5] = '{8'h00, 8'h80, -1};
        vecs[6] = '{8'h3C, 8'h03,  2};
        vecs[7] = '{8'h7F, 8'h80,  6};

        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_value", sval(value), 0);
        RST = 1'b0;
        tick();

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ready_idle_ignored", int'(out_valid | busy), 0);

        for (int v = 0; v < 8; v++) begin
            convert(vecs[v].p, vecs[v].m, 8'h00, vecs[v].expv);
            consume(1'b0, 0);
            check("value_kept_idle", sval(value), vecs[v].expv);
        end

        // Stall in HOLD with start and input noise, then back-to-back restart.
        convert(8'hFF, 8'h00, 8'h00, 8);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            in_p  = 1'($urandom_range(0, 1));
            in_m  = 1'($urandom_range(0, 1));
            tick();
            check("stall_valid", int'(out_valid), 1);
            check("stall_value", sval(value), 8);
        end
        start = 1'b0;
        in_p  = 1'b0;
        in_m  = 1'b0;
        consume(1'b1, -8);
        drive_samples(8'h00, 8'hFF, 8'h00);
        consume(1'b0, 0);

        // start re-pulsed at samples 3 and 6 must not restart the window.
        convert(8'hFF, 8'h00, 8'h48, 8);
        consume(1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second_conv", int'(busy | out_valid), 0);
        end

        // Reset during sample 5 aborts the conversion asynchronously.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_p  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("value_stable_in_accum", sval(value), 8);
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_value", sval(value), 0);
        #2;
        RST  = 1'b0;
        in_p = 1'b0;
        tick();
        tick();
        check("post_rst_idle", int'(busy | out_valid), 0);
        convert(8'hFF, 8'h00, 8'h00, 8);
        consume(1'b0, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
